seg_scan_display: RTL and testbench

SEG_SCAN_DISPLAY -- requirements
Module: seg_scan_display

---
 rtl/seg_scan_display.sv | 181 ++++++++++++++++++
 tb/tb_seg_scan_display.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_display.sv
// Four-digit multiplexed seven-segment driver with blanking gaps between digits,
// frame-synchronous value commit, per-digit decimal points and leading-zero blanking.
module seg_scan_display #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  dp_mask,
  input  logic        lz_blank,
  output logic [3:0]  AN,
  output logic [7:0]  Out,
  output logic        frame_done,
  output logic        pending
);

  localparam int MAX_CNT = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(BLANK_CYCLES - 1);

  generate
    if (REFRESH_DIV < 1 || BLANK_CYCLES < 1) begin : g_param_check
      $error("seg_scan_display: REFRESH_DIV and BLANK_CYCLES must both be >= 1");
    end
  endgenerate

  typedef enum logic {
    PH_SHOW = 1'b0,
    PH_GAP  = 1'b1
  } phase_t;

  // Scan state
  phase_t           r_phase;
  logic [1:0]       r_digit;
  logic [CNT_W-1:0] r_cnt;

  // Registered outputs
  logic [3:0] r_an;
  logic [7:0] r_out;
  logic       r_frame_done;

  // Displayed (committed) and pending (loaded, not yet committed) contents
  logic [15:0] r_disp_val;
  logic [3:0]  r_disp_dp;
  logic        r_disp_lz;
  logic [15:0] r_pend_val;
  logic [3:0]  r_pend_dp;
  logic        r_pend_lz;
  logic        r_pending;

  logic       w_phase_end;
  logic       w_frame_end;
  logic [3:0] w_nibble;
  logic       w_blank;
  logic [6:0] w_seg;

  assign w_phase_end = (r_phase == PH_SHOW) ? (r_cnt == SHOW_LAST) : (r_cnt == GAP_LAST);
  assign w_frame_end = (r_phase == PH_GAP) && (r_digit == 2'd3) && (r_cnt == GAP_LAST);

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_nibble = r_disp_val[3:0];
    w_blank  = 1'b0;
    case (r_digit)
      2'd1: begin
        w_nibble = r_disp_val[7:4];
        w_blank  = r_disp_lz && (r_disp_val[15:4] == 12'h000);
      end
      2'd2: begin
        w_nibble = r_disp_val[11:8];
        w_blank  = r_disp_lz && (r_disp_val[15:8] == 8'h00);
      end
      2'd3: begin
        w_nibble = r_disp_val[15:12];
        w_blank  = r_disp_lz && (r_disp_val[15:12] == 4'h0);
      end
      default: begin
        w_nibble = r_disp_val[3:0];
        w_blank  = 1'b0;
      end
    endcase
  end

  // Active-low segments g..a
  always_comb begin
    w_seg = 7'h7F;
    case (w_nibble)
      4'h0: w_seg = 7'h40;
      4'h1: w_seg = 7'h79;
      4'h2: w_seg = 7'h24;
      4'h3: w_seg = 7'h30;
      4'h4: w_seg = 7'h19;
      4'h5: w_seg = 7'h12;
      4'h6: w_seg = 7'h02;
      4'h7: w_seg = 7'h78;
      4'h8: w_seg = 7'h00;
      4'h9: w_seg = 7'h10;
      4'hA: w_seg = 7'h08;
      4'hB: w_seg = 7'h03;
      4'hC: w_seg = 7'h46;
      4'hD: w_seg = 7'h21;
      4'hE: w_seg = 7'h06;
      4'hF: w_seg = 7'h0E;
      default: w_seg = 7'h7F;
    endcase
  end

  // Scan FSM; AN/Out are registered from the current state, so they trail it by one clock.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_phase      <= PH_SHOW;
      r_digit      <= 2'd0;
      r_cnt        <= '0;
      r_an         <= 4'b1111;
      r_out        <= 8'hFF;
      r_frame_done <= 1'b0;
    end else begin
      if (w_phase_end) begin
        r_cnt <= '0;
        if (r_phase == PH_SHOW) begin
          r_phase <= PH_GAP;
        end else begin
          r_phase <= PH_SHOW;
          r_digit <= r_digit + 2'd1;
        end
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      if (r_phase == PH_SHOW) begin
        r_an  <= ~(4'b0001 << r_digit);
        r_out <= w_blank ? 8'hFF : {~r_disp_dp[r_digit], w_seg};
      end else begin
        r_an  <= 4'b1111;
        r_out <= 8'hFF;
      end

      r_frame_done <= w_frame_end;
    end
  end

  // Loads park in the pending register and only reach the display at the frame boundary,
  // so a frame never mixes digits of two different values.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_disp_val <= 16'h0000;
      r_disp_dp  <= 4'h0;
      r_disp_lz  <= 1'b0;
      r_pend_val <= 16'h0000;
      r_pend_dp  <= 4'h0;
      r_pend_lz  <= 1'b0;
      r_pending  <= 1'b0;
    end else if (w_frame_end) begin
      if (load) begin
        r_disp_val <= value;
        r_disp_dp  <= dp_mask;
        r_disp_lz  <= lz_blank;
      end else if (r_pending) begin
        r_disp_val <= r_pend_val;
        r_disp_dp  <= r_pend_dp;
        r_disp_lz  <= r_pend_lz;
      end
      r_pending <= 1'b0;
    end else if (load) begin
      r_pend_val <= value;
      r_pend_dp  <= dp_mask;
      r_pend_lz  <= lz_blank;
      r_pending  <= 1'b1;
    end
  end

  assign AN         = r_an;
  assign Out        = r_out;
  assign frame_done = r_frame_done;
  assign pending    = r_pending;

endmodule

// File: tb/tb_seg_scan_display.sv
// Bench for seg_scan_display: a time-indexed frame model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_seg_scan_display;

  localparam int R     = 4;
  localparam int B     = 2;
  localparam int PER   = R + B;
  localparam int FRAME = 4 * PER;

  localparam logic [7:0] HEX_SEG [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_mask;
  logic        lz_blank;
  logic [3:0]  AN;
  logic [7:0]  Out;
  logic        frame_done;
  logic        pending;

  int n_vec = 0;
  int n_err = 0;
  int e     = 0;

  seg_scan_display #(.REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
    .clk        (clk),
    .Reset      (rst),
    .load       (load),
    .value      (value),
    .dp_mask    (dp_mask),
    .lz_blank   (lz_blank),
    .AN         (AN),
    .Out        (Out),
    .frame_done (frame_done),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", name, act, exp, e, $time);
    end
  endtask

  // Model: scan position follows directly from the number of clocks since reset release.
  int          t = 0;
  logic [15:0] m_disp_val = '0, m_pend_val = '0;
  logic [3:0]  m_disp_dp = '0, m_pend_dp = '0;
  logic        m_disp_lz = 1'b0, m_pend_lz = 1'b0, m_pend = 1'b0;
  logic [3:0]  exp_an = 4'hF;
  logic [7:0]  exp_out = 8'hFF;
  logic        exp_fd = 1'b0;
  logic        exp_pend = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      t = 0;
      m_disp_val = '0; m_disp_dp = '0; m_disp_lz = 1'b0;
      m_pend_val = '0; m_pend_dp = '0; m_pend_lz = 1'b0; m_pend = 1'b0;
      exp_an = 4'hF; exp_out = 8'hFF; exp_fd = 1'b0; exp_pend = 1'b0;
    end else begin
      int pos, dig;
      logic [3:0] nib;
      pos = t % FRAME;
      dig = pos / PER;
      if ((pos % PER) < R) begin
        exp_an = ~(4'b0001 << dig);
        nib = 4'(m_disp_val >> (4 * dig));
        if (m_disp_lz && dig != 0 && (m_disp_val >> (4 * dig)) == 16'h0) begin
          exp_out = 8'hFF;
        end else begin
          exp_out = HEX_SEG[nib];
          if (m_disp_dp[dig]) exp_out[7] = 1'b0;
        end
      end else begin
        exp_an  = 4'hF;
        exp_out = 8'hFF;
      end
      exp_fd = (pos == FRAME - 1);
      if (pos == FRAME - 1) begin
        if (load) begin
          m_disp_val = value; m_disp_dp = dp_mask; m_disp_lz = lz_blank;
        end else if (m_pend) begin
          m_disp_val = m_pend_val; m_disp_dp = m_pend_dp; m_disp_lz = m_pend_lz;
        end
        m_pend = 1'b0;
      end else if (load) begin
        m_pend_val = value; m_pend_dp = dp_mask; m_pend_lz = lz_blank; m_pend = 1'b1;
      end
      exp_pend = m_pend;
      t++;
    end
  end

  always @(negedge clk) begin
    check("AN", 16'(AN), 16'(exp_an));
    check("Out", 16'(Out), 16'(exp_out));
    check("frame_done", 16'(frame_done), 16'(exp_fd));
    check("pending", 16'(pending), 16'(exp_pend));
  end

  task automatic tick();
    @(negedge clk);
    e++;
  endtask

  task automatic run_to(input int n);
    while (e < n) tick();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic lz);
    load = 1'b1; value = v; dp_mask = dp; lz_blank = lz;
    tick();
    load = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; load = 1'b0; value = '0; dp_mask = '0; lz_blank = 1'b0;
    repeat (3) @(negedge clk);
    check("reset AN", 16'(AN), 16'h000F);
    check("reset Out", 16'(Out), 16'h00FF);
    check("reset pending", 16'(pending), 16'h0);
    rst = 1'b0; e = 0;

    // Free-running scan with no load
    run_to(1);
    check("e1 AN", 16'(AN), 16'h000E);
    check("e1 Out", 16'(Out), 16'h00C0);
    check("model e1 AN", 16'(exp_an), 16'h000E);
    run_to(5);
    check("e5 gap AN", 16'(AN), 16'h000F);
    run_to(7);
    check("e7 AN", 16'(AN), 16'h000D);
    run_to(19);
    check("e19 AN", 16'(AN), 16'h0007);
    run_to(23);
    check("e23 frame_done", 16'(frame_done), 16'h0);
    run_to(24);
    check("e24 frame_done", 16'(frame_done), 16'h1);
    check("model e24 frame_done", 16'(exp_fd), 16'h1);

    // Mid-frame load waits for the frame boundary
    run_to(30);
    do_load(16'h12AF, 4'b0001, 1'b0);
    check("load pending", 16'(pending), 16'h1);
    run_to(33);
    check("no tear Out", 16'(Out), 16'h00C0);
    run_to(48);
    check("commit fd", 16'(frame_done), 16'h1);
    check("commit pending", 16'(pending), 16'h0);
    run_to(49);
    check("12AF d0 AN", 16'(AN), 16'h000E);
    check("12AF d0 Out", 16'(Out), 16'h000E);
    check("model 12AF d0", 16'(exp_out), 16'h000E);
    run_to(55);
    check("12AF d1 Out", 16'(Out), 16'h0088);
    run_to(61);
    check("12AF d2 Out", 16'(Out), 16'h00A4);
    run_to(67);
    check("12AF d3 Out", 16'(Out), 16'h00F9);
    check("12AF d3 AN", 16'(AN), 16'h0007);

    // Two loads in one frame: newest wins
    run_to(74);
    do_load(16'h1111, 4'b0000, 1'b0);
    run_to(79);
    do_load(16'h2222, 4'b0000, 1'b0);
    run_to(97);  check("2222 d0", 16'(Out), 16'h00A4);
    run_to(103); check("2222 d1", 16'(Out), 16'h00A4);
    run_to(109); check("2222 d2", 16'(Out), 16'h00A4);
    run_to(115); check("2222 d3", 16'(Out), 16'h00A4);

    // Leading-zero blanking
    run_to(120);
    do_load(16'h0050, 4'b0000, 1'b1);
    run_to(145); check("lz d0 Out", 16'(Out), 16'h00C0);
    run_to(151); check("lz d1 Out", 16'(Out), 16'h0092);
    run_to(157);
    check("lz d2 Out", 16'(Out), 16'h00FF);
    check("lz d2 AN", 16'(AN), 16'h000B);
    run_to(163);
    check("lz d3 Out", 16'(Out), 16'h00FF);
    check("lz d3 AN", 16'(AN), 16'h0007);

    // Load exactly on the frame boundary commits directly
    run_to(167);
    do_load(16'h0007, 4'b0000, 1'b0);
    check("boundary pending", 16'(pending), 16'h0);
    check("boundary fd", 16'(frame_done), 16'h1);
    run_to(169);
    check("boundary d0 Out", 16'(Out), 16'h00F8);

    // Async reset during digit 2 SHOW with a load pending
    do_load(16'h3333, 4'b0000, 1'b0);
    check("pre-reset pending", 16'(pending), 16'h1);
    run_to(181);
    check("pre-reset AN", 16'(AN), 16'h000B);
    #2 rst = 1'b1;
    #1;
    check("async AN", 16'(AN), 16'h000F);
    check("async Out", 16'(Out), 16'h00FF);
    check("async pending", 16'(pending), 16'h0);
    check("async fd", 16'(frame_done), 16'h0);
    tick(); tick();
    rst = 1'b0; e = 0;
    run_to(1);
    check("post-reset AN", 16'(AN), 16'h000E);
    check("post-reset Out", 16'(Out), 16'h00C0);
    check("post-reset pending", 16'(pending), 16'h0);
    run_to(2 * FRAME + 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
